// File: rtl/wb_lsu_pkg.sv
// Shared definitions for the wb_lsu load/store unit.
// Contents: size_i encodings, FSM state enum, byte-count helper.
// Build option: LSU_ALIGN_CHECK_EN (consumed by wb_lsu).
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HWORD = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Number of bytes moved by an access of the given size code (1,2,4,8).
  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/wb_lsu_if.sv
// Pipelined Wishbone B.4 master-port bundle used by wb_lsu.
// Signals: wbmadr_o, wbmdat_o, wbmsel_o, wbmwe_o, wbmstb_o, wbmcyc_o
// (master to slave) and wbmack_i, wbmstall_i, wbmerr_i, wbmdat_i
// (slave to master). Suffixes are from the LSU's point of view.
interface wb_lsu_if #(
  parameter int BUS_WIDTH = 16
) ();
  localparam int BUS_BYTES = BUS_WIDTH / 8;

  logic [63:0]          wbmadr_o;
  logic [BUS_WIDTH-1:0] wbmdat_o;
  logic [BUS_BYTES-1:0] wbmsel_o;
  logic                 wbmwe_o;
  logic                 wbmstb_o;
  logic                 wbmcyc_o;
  logic                 wbmack_i;
  logic                 wbmstall_i;
  logic                 wbmerr_i;
  logic [BUS_WIDTH-1:0] wbmdat_i;

  modport master (
    output wbmadr_o, wbmdat_o, wbmsel_o, wbmwe_o, wbmstb_o, wbmcyc_o,
    input  wbmack_i, wbmstall_i, wbmerr_i, wbmdat_i
  );

  modport slave (
    input  wbmadr_o, wbmdat_o, wbmsel_o, wbmwe_o, wbmstb_o, wbmcyc_o,
    output wbmack_i, wbmstall_i, wbmerr_i, wbmdat_i
  );
endinterface

// File: rtl/wb_lsu_lane.sv
// lsu_lane: combinational byte-lane steering for wb_lsu.
// Ports:
//   size_i, signed_i   access size code and load sign-extension enable
//   off_i              byte offset of the access inside a bus word
//   beat_i             current store beat index
//   st_dat_i           right-justified store data
//   ld_raw_i           assembled load data (beat 0 in the low bits)
//   sel_o, wdat_o      byte selects and write data for the current beat
//   ld_res_o           extracted and extended load result
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input  logic [1:0]                     size_i,
  input  logic                           signed_i,
  input  logic [$clog2(BUS_WIDTH/8)-1:0] off_i,
  input  logic [1:0]                     beat_i,
  input  logic [63:0]                    st_dat_i,
  input  logic [63:0]                    ld_raw_i,
  output logic [BUS_WIDTH/8-1:0]         sel_o,
  output logic [BUS_WIDTH-1:0]           wdat_o,
  output logic [63:0]                    ld_res_o
);
  localparam int         BUS_BYTES = BUS_WIDTH / 8;
  localparam logic [3:0] BB        = 4'(BUS_BYTES);

  function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz,
                                         input logic sgn);
    case (sz)
      SZ_BYTE:  return {{56{sgn & v[7]}},  v[7:0]};
      SZ_HWORD: return {{48{sgn & v[15]}}, v[15:0]};
      SZ_WORD:  return {{32{sgn & v[31]}}, v[31:0]};
      default:  return v;
    endcase
  endfunction

  logic [3:0]           nbytes;
  logic                 sub;
  logic [BUS_BYTES-1:0] mask;
  logic [3:0]           idx;
  logic [63:0]          shifted;

  assign nbytes = size_bytes(size_i);
  assign sub    = (nbytes < BB);

  always_comb begin
    mask   = '0;
    idx    = '0;
    sel_o  = '1;
    wdat_o = st_dat_i[int'(beat_i) * BUS_WIDTH +: BUS_WIDTH];
    if (sub) begin
      for (int i = 0; i < BUS_BYTES; i++) begin
        mask[i] = (4'(i) < nbytes);
        // Lane i carries store byte (i mod access_bytes): replication.
        idx = 4'(i) & (nbytes - 4'd1);
        wdat_o[i*8 +: 8] = st_dat_i[{idx[2:0], 3'b000} +: 8];
      end
      sel_o = mask << off_i;
    end
  end

  // Wide accesses are aligned, so off_i is zero for them and the shift is a no-op.
  assign shifted  = ld_raw_i >> {off_i, 3'b000};
  assign ld_res_o = extend(shifted, size_i, signed_i);

endmodule

// File: rtl/wb_lsu.sv
// wb_lsu: load/store unit bridging the 64-bit execute stage to a
// pipelined Wishbone B.4 master port of BUS_WIDTH bits (16/32/64).
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   valid_i, nomem_i, we_i   start access / pass-through / store select
//   size_i, signed_i         access size, load sign extension
//   addr_i, dat_i            effective address (or pass value), store data
//   busy_o, rwe_o, dat_o     bus cycle active, register write strobe, result
//   err_o                    one-cycle access fault
//   wb                       Wishbone master port (wb_lsu_if.master)
// Build option: LSU_ALIGN_CHECK_EN rejects misaligned accesses with err_o;
// without it the low address bits of an access are forced to zero.
module wb_lsu
  import lsu_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic        nomem_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] dat_i,
  output logic        busy_o,
  output logic        rwe_o,
  output logic [63:0] dat_o,
  output logic        err_o,
  wb_lsu_if.master    wb
);
  localparam int         BUS_BYTES = BUS_WIDTH / 8;
  localparam int         OFFW      = $clog2(BUS_BYTES);
  localparam logic [3:0] BB        = 4'(BUS_BYTES);

  state_e               state_q, state_d;
  logic [63:0]          addr_q, addr_d, sdat_q, sdat_d, asm_q, asm_d, dat_q, dat_d;
  logic [1:0]           size_q, size_d;
  logic                 sgn_q, sgn_d, we_q, we_d, rwe_q, rwe_d, err_q, err_d;
  logic [3:0]           beat_q, beat_d, ack_q, ack_d;
  logic [3:0]           nbytes, nbeats;
  logic [63:0]          amask, asm_mrg, ld_res;
  logic [BUS_WIDTH-1:0] wdat;
  logic [BUS_BYTES-1:0] sel;
  logic                 go, stb;

  assign nbytes = size_bytes(size_q);
  assign nbeats = (nbytes <= BB) ? 4'd1 : (nbytes >> OFFW);
  assign amask  = 64'(size_bytes(size_i)) - 64'd1;

`ifdef LSU_ALIGN_CHECK_EN
  logic misal;
  assign misal = |(addr_i & amask);
`endif

  // Assembly register with the beat arriving this cycle already merged, so
  // the final ack can write the extended result in the same cycle.
  always_comb begin
    asm_mrg = asm_q;
    asm_mrg[int'(ack_q[1:0]) * BUS_WIDTH +: BUS_WIDTH] = wb.wbmdat_i;
  end

  lsu_lane #(.BUS_WIDTH(BUS_WIDTH)) u_lane (
    .size_i   (size_q),
    .signed_i (sgn_q),
    .off_i    (addr_q[OFFW-1:0]),
    .beat_i   (beat_q[1:0]),
    .st_dat_i (sdat_q),
    .ld_raw_i (asm_mrg),
    .sel_o    (sel),
    .wdat_o   (wdat),
    .ld_res_o (ld_res)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sdat_q  <= '0;
      asm_q   <= '0;
      dat_q   <= '0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      we_q    <= 1'b0;
      rwe_q   <= 1'b0;
      err_q   <= 1'b0;
      beat_q  <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sdat_q  <= sdat_d;
      asm_q   <= asm_d;
      dat_q   <= dat_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      we_q    <= we_d;
      rwe_q   <= rwe_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sdat_d  = sdat_q;
    asm_d   = asm_q;
    dat_d   = dat_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    we_d    = we_q;
    beat_d  = beat_q;
    ack_d   = ack_q;
    rwe_d   = 1'b0;
    err_d   = 1'b0;
    go      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (nomem_i) begin
          dat_d = addr_i;
          rwe_d = 1'b1;
        end else if (valid_i) begin
`ifdef LSU_ALIGN_CHECK_EN
          go    = ~misal;
          err_d = misal;
`else
          go    = 1'b1;
`endif
          if (go) begin
            addr_d  = addr_i & ~amask;
            size_d  = size_i;
            sgn_d   = signed_i;
            we_d    = we_i;
            sdat_d  = dat_i;
            beat_d  = '0;
            ack_d   = '0;
            asm_d   = '0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (wb.wbmerr_i) begin
          // Error wins over a simultaneous ack; remaining beats are dropped.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (state_q == ST_ISSUE && !wb.wbmstall_i) begin
            beat_d = beat_q + 4'd1;
            if (beat_q == nbeats - 4'd1) state_d = ST_WAIT;
          end
          if (wb.wbmack_i) begin
            asm_d = asm_mrg;
            ack_d = ack_q + 4'd1;
            if (ack_q + 4'd1 == nbeats) begin
              state_d = ST_IDLE;
              if (!we_q) begin
                dat_d = ld_res;
                rwe_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stb          = (state_q == ST_ISSUE);
  assign busy_o       = (state_q != ST_IDLE);
  assign rwe_o        = rwe_q;
  assign err_o        = err_q;
  assign dat_o        = dat_q;
  assign wb.wbmcyc_o  = (state_q != ST_IDLE);
  assign wb.wbmstb_o  = stb;
  assign wb.wbmwe_o   = stb & we_q;
  assign wb.wbmadr_o  = stb ? ({addr_q[63:OFFW], {OFFW{1'b0}}} + (64'(beat_q) << OFFW)) : '0;
  assign wb.wbmdat_o  = stb ? wdat : '0;
  assign wb.wbmsel_o  = stb ? sel : '0;

endmodule
